// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Used by seq_mul_ctrl and seq_multiplier (optional MUL_EARLY_EXIT_EN build).
package mul_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } mul_state_e;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Sequencer for seq_multiplier: FSM, iteration counter and registered busy/done.
// MUL_EARLY_EXIT_EN lets CALC finish as soon as the remaining multiplier bits are zero.
module seq_mul_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q_rest_zero,
    output logic load,
    output logic iter,
    output logic busy,
    output logic done
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mul_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_iter;

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == LastCnt) || q_rest_zero;
`else
    logic unused_q_rest_zero;
    assign unused_q_rest_zero = q_rest_zero;
    assign last_iter = (cnt_q == LastCnt);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        iter    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                iter  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Datapath convention: all state moves on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per falling edge.
// Define MUL_EARLY_EXIT_EN to stop iterating once the remaining multiplier bits are zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] m_q;
    logic [WIDTH-1:0]   q_q;
    logic               load;
    logic               iter;
    logic               q_rest_zero;

    // True when the multiplier bits left after this iteration's shift are all zero.
    assign q_rest_zero = (q_q[WIDTH-1:1] == '0);

    seq_mul_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .q_rest_zero(q_rest_zero),
        .load       (load),
        .iter       (iter),
        .busy       (busy),
        .done       (done)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            m_q <= '0;
            q_q <= '0;
        end else if (load) begin
            p_q <= '0;
            m_q <= {{WIDTH{1'b0}}, mcand};
            q_q <= mplier;
        end else if (iter) begin
            if (q_q[0]) begin
                p_q <= p_q + m_q;
            end
            m_q <= m_q << 1;
            q_q <= q_q >> 1;
        end
    end

    assign product = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands
// against an arithmetic reference (product and expected latency).
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Edges from acceptance to done, from the multiplier value alone.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n;
`else
        return W;
`endif
    endfunction

    // Called at a rising edge; start is seen at the next falling edge.
    // inject_at > 0 raises start with 9*9 so that it is seen at edge E<inject_at>.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
        int  lat;
        bit  seen;
        logic [31:0] exp_p;
        exp_p  = a * b;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        @(posedge clk);
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= W + 4 && !seen; k++) begin
            if (k == inject_at) begin
                start  = 1'b1;
                mcand  = 9;
                mplier = 9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            @(posedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else if (busy !== 1'b1) begin
                check_eq("busy_during_calc", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", lat, exp_lat(b));
        check_eq("product", 32'(product), exp_p);
        check_eq("busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        @(posedge clk);
        check_eq("done_fell", 32'(done), 32'd0);
        check_eq("busy_fell", 32'(busy), 32'd0);
        check_eq("product_held", 32'(product), exp_p);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        check_eq("rst_product", 32'(product), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk);

        run_op(8'd13, 8'd11, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd0, 8'd200, 0);
        run_op(8'd200, 8'd0, 0);
        // Start during CALC is dropped; the next IDLE cycle is accepted.
        run_op(8'd6, 8'd7, 3);
        run_op(8'd9, 8'd9, 0);
        run_op(8'd200, 8'd1, 0);
        run_op(8'd200, 8'h80, 0);

        // Reset mid-operation aborts without a done pulse.
        start  = 1'b1;
        mcand  = 8'd100;
        mplier = 8'd100;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk);
        end
        rst = 1'b1;
        #1;
        check_eq("abort_product", 32'(product), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            @(posedge clk);
            if (done !== 1'b0 || product !== '0)
                check_eq("abort_idle_quiet", {15'd0, done, product}, 32'd0);
        end
        check_eq("abort_idle_product", 32'(product), 32'd0);
        run_op(8'd3, 8'd5, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-and-add multiplier, the multiply-side counterpart of the team's sequential divider datapath. It latches two WIDTH-bit operands on a start request and iterates one multiplier bit per clock. It returns a 2*WIDTH-bit product with a one-cycle done pulse. It sits beside the divider in the arithmetic unit and is driven by the same kind of controller (start/done handshake, no back-pressure).

## Interface

- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the falling edge of clk (datapath convention).
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- mcand  input  WIDTH  multiplicand, sampled with start.
- mplier  input  WIDTH  multiplier, sampled with start.
- product  output  2*WIDTH  result register.
- busy  output  1  high from the edge that accepts start through the edge that leaves DONE.
- done  output  1  one-cycle pulse; product valid.

## Operation

- Registers:
  - P (2*WIDTH) is the accumulator and drives product.
  - M (2*WIDTH) is the shifted multiplicand.
  - Q (WIDTH) is the remaining multiplier bits.
  - cnt holds ceil(log2 WIDTH) bits.
  - state is one of IDLE, CALC, DONE.
- Reset (asynchronous) forces state=IDLE, P=M=0, Q=0, cnt=0, product=0, busy=0, done=0.
- IDLE:
  - On start=1, load P=0, M={WIDTH'b0, mcand}, Q=mplier, cnt=0, and go to CALC.
  - On start=0, all registers hold; product keeps the last result.
- CALC, each edge:
  - If Q[0], P = P + M (2*WIDTH-bit add; it cannot overflow).
  - Then M = M << 1, Q = Q >> 1, cnt = cnt + 1.
  - Leave CALC for DONE on the edge where cnt == WIDTH-1, i.e. after exactly WIDTH iterations.
- DONE: done=1 for this single state, product = mcand*mplier, then unconditionally return to IDLE.
- start is ignored in CALC and DONE. It is not queued.
- A start that is high in the IDLE cycle following DONE is accepted. Back-to-back throughput is therefore one result per WIDTH+2 cycles.
- Operand inputs may change freely after the accepting edge.
- During CALC, product shows partial sums and is not meaningful. Consumers qualify it with done, or read it in IDLE after done.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and product reads 0.

## Timing

- E0 is the falling edge at which start=1 is seen in IDLE. At E0: operands are latched, busy rises, state=CALC.
- E1..EWIDTH are the iteration edges. At EWIDTH, state becomes DONE and done rises.
- At EWIDTH+1: done falls, busy falls, state=IDLE.
- Latency from the accepting edge to done: WIDTH edges (8 for the default).
- done and busy are registered outputs; they have no combinational path from start.

## Configuration

- MUL_EARLY_EXIT_EN, when defined:
  - CALC also exits to DONE on the edge where the shifted Q becomes zero, even if fewer than WIDTH iterations have run.
  - CALC always runs at least one iteration.
  - mplier==0 or mplier==1 gives done at E1. mplier==8'h80 still takes 8 iterations.
  - Product is identical to the non-early-exit result.
- MUL_EARLY_EXIT_EN, when not defined: always exactly WIDTH iterations, giving fixed latency.

## Structure

- Shared package mul_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default WIDTH constant;
  - the counter-width function.
- Split the block into two parts:
  - sub-module seq_mul_ctrl, which holds the FSM and cnt and produces the load, iterate, busy and done controls;
  - the top level, which holds the P/M/Q datapath.

## Test plan

- Reset, then mcand=13, mplier=11, start for one cycle -> done at E8, product=143 (16'h008F); busy high E0..E8.
- mcand=255, mplier=255 -> product=65025 (16'hFE01), no overflow.
- mcand=0, mplier=200, and separately mcand=200, mplier=0 -> product=0 in both cases.
- Start 6*7. Raise start again at E3 with operands 9*9 -> ignored, product=42. Start 9*9 in the IDLE cycle after done -> product=81.
- Start 100*100. Assert rst at E4 -> state IDLE, product=0, no done pulse. After release, 3*5 -> 15.
- mcand=200, mplier=1 -> with MUL_EARLY_EXIT_EN, done at E1 and product=200; without it, done at E8 and product=200. Also run mplier=8'h80 -> done at E8 in both builds, product=25600.
